porta_ctrl_encoder: RTL
=======================

Name: porta_ctrl_encoder

Overview:
- Controller front end for the portable console. Scans a 4x3 membrane keypad and six direct buttons, debounces them, and encodes the result onto the seven active-low controller lines (P1-P4, P6, P7, P9).
- Sits directly upstream of the console glue logic. Its pin outputs drive the glue's C1Px inputs.
- The glue's CP5_ARM and CP8_FIRE strobes come back into this block as the joystick and keypad select inputs.

Parameters:
- SCAN_DIV, 1024, clocks each keypad row is driven before it is sampled (min 4).
- DEBOUNCE_CNT, 4, consecutive identical scan frames needed to commit a new state (min 1, max 15).
- TURBO_DIV, 16, frames per autofire half-period (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- row_n  out  4  keypad row drive, active-low, one row low at a time
- col_n  in  3  keypad column sense, active-low, asynchronous
- btn_n  in  6  direct buttons, active-low, asynchronous: [0] up, [1] down, [2] left, [3] right, [4] fire_l, [5] fire_r
- sel_joy_n  in  1  joystick select from glue CP5_ARM, active-low
- sel_key_n  in  1  keypad select from glue CP8_FIRE, active-low
- p1, p2, p3, p4, p6, p7, p9  out  1 each  controller pins, active-low
- key_code  out  4  committed keypad code, 4'hF = no key
- key_valid  out  1  high while a committed key is pressed

Behaviour:
- **Synchronisers:** col_n and btn_n each pass through a 2-FF synchroniser before use.
- **Scan FSM states:**
  - IDLE: the reset state. Goes to DRIVE on the first clock after rst falls.
  - DRIVE: holds the current row low for SCAN_DIV clocks. On the final clock of the dwell it latches the synchronised columns for that row, then goes to NEXT.
  - NEXT: advances the row pointer 0,1,2,3,0 with wrap-around. After row 3 it goes to FRAME, otherwise back to DRIVE.
  - FRAME: evaluates one complete frame for one clock, then goes to DRIVE with row 0.
- **Frame period:** 4*(SCAN_DIV+1)+1 clocks.
- **Key mapping:**
  - Rows 0-3 by columns 0-2 give the keys 1,2,3 / 4,5,6 / 7,8,9 / *,0,#.
  - If several keys are pressed, the lowest row-major index wins.
- **Raw codes** ({p4,p3,p2,p1}, bit0 = p1):
  - 1=D, 2=7, 3=C, 4=2, 5=3, 6=E, 7=5, 8=1, 9=B, 0=A, *=9, #=6.
  - No key = F.
- **Debounce:**
  - In FRAME, the candidate {key code, 6 button bits} is compared with the previous frame's candidate.
  - If equal, a 4-bit stable counter increments, saturating at DEBOUNCE_CNT. If different, the counter is cleared.
  - When the counter reaches DEBOUNCE_CNT, the candidate is committed.
  - key_code and key_valid update on the clock after commit; key_valid = (key_code != F).
- **Pin mux** (registered, one-clock latency from any select or committed-state change):
  - Keypad mode (sel_key_n=0, sel_joy_n=1): {p4..p1} = key_code; p6 = btn fire_r.
  - Joystick mode (sel_joy_n=0, sel_key_n=1): p1=up, p2=down, p3=left, p4=right, p6=fire_l. Pins are active-low, so a pressed button gives 0.
  - Both selects low: each pin is the AND of its keypad-mode and joystick-mode values (wired-AND).
  - Both selects high: p1-p4 and p6 are 1.
  - p7 and p9 are always 1 (no spinner).
- **Reset** (any cycle, including mid-scan):
  - row_n=4'hF; all p pins = 1; key_code=F; key_valid=0.
  - Stable counter, candidate and committed state are cleared to "released". The FSM returns to IDLE.
  - The first row is driven on the clock after rst deasserts.

Optional Feature:
- Macro: PORTA_CTRL_TURBO_EN.
- Defined:
  - A frame counter toggles a turbo phase every TURBO_DIV frames.
  - While a committed fire button is held, its pin output is gated by the phase: pressed-and-phase=1 drives 0, otherwise 1.
  - The phase counter is cleared by rst.
- Undefined: the turbo logic is absent and fire pins follow the committed state directly.

Test Plan:
- Reset and scan start: hold rst 10 clocks, then release; SCAN_DIV=8, no keys pressed.
  - During reset: row_n=F and all pins 1.
  - First clock after release: row_n=E.
  - Row pointer wraps every 37 clocks.
- Keypad '5': press key 5 (row 1, col 1); sel_key_n=0, sel_joy_n=1; DEBOUNCE_CNT=4.
  - After 4 stable frames: key_code=3, key_valid=1, {p4..p1}=0011.
  - After release and 4 frames: code returns to F.
- Bounce rejection: toggle key '1' every frame for 10 frames.
  - key_valid stays 0 and key_code stays F throughout.
- Joystick mode: sel_joy_n=0, sel_key_n=1; press up and fire_l.
  - After commit: p1=0, p6=0, p2=1, p3=1, p4=1, p7=1, p9=1.
  - Both selects high: pins return to 1 one clock later.
- Multi-key and wired-AND:
  - Press keys 1 and 9: key_code=D.
  - Both selects low with right pressed: p4=0, {p3,p2,p1}=101.
- Mid-scan reset: assert rst in the middle of a DRIVE dwell with key 0 committed.
  - Next clock: key_valid=0, key_code=F, row_n=F.
  - Commit recurs only after 4 fresh frames.

Source files
------------

// File: rtl/porta_ctrl_encoder.sv
// porta_ctrl_encoder: keypad scanner, debouncer and controller pin encoder.
// Optional autofire gating on the fire pins: define PORTA_CTRL_TURBO_EN.
module porta_ctrl_encoder #(
  parameter int SCAN_DIV     = 1024,
  parameter int DEBOUNCE_CNT = 4
`ifdef PORTA_CTRL_TURBO_EN
  ,
  parameter int TURBO_DIV    = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row_n,
  input  logic [2:0] col_n,
  input  logic [5:0] btn_n,
  input  logic       sel_joy_n,
  input  logic       sel_key_n,
  output logic       p1,
  output logic       p2,
  output logic       p3,
  output logic       p4,
  output logic       p6,
  output logic       p7,
  output logic       p9,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    NEXT,
    FRAME
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    row_q, row_d;
  logic [DW-1:0] div_q, div_d;
  logic          latch;

  logic [2:0]      col_m_q, col_s_q;
  logic [5:0]      btn_m_q, btn_s_q;
  logic [3:0][2:0] scan_q;

  logic [11:0] pr;
  logic [3:0]  code_c;
  logic [9:0]  cand;
  logic [9:0]  cand_q, cand_d;
  logic [9:0]  com_q, com_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [3:0]  key_code_q;
  logic        key_valid_q;
  logic        fire_l, fire_r;
  logic [4:0]  kp, jy;
  logic [4:0]  pins_q, pins_d;

  // Two-flop synchronisers for the asynchronous keypad and button inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      col_m_q <= '1;
      col_s_q <= '1;
      btn_m_q <= '1;
      btn_s_q <= '1;
    end else begin
      col_m_q <= col_n;
      col_s_q <= col_m_q;
      btn_m_q <= btn_n;
      btn_s_q <= btn_m_q;
    end
  end

  // Scan state, row pointer and dwell counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      div_q   <= div_d;
    end
  end

  // Scan sequencing: dwell on each row, step rows, one evaluation clock
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    div_d   = div_q;
    latch   = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = DRIVE;
        row_d   = '0;
        div_d   = '0;
      end
      DRIVE: begin
        if (div_q == DW'(SCAN_DIV - 1)) begin
          latch   = 1'b1;
          div_d   = '0;
          state_d = NEXT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      NEXT: begin
        row_d   = row_q + 2'd1;
        state_d = (row_q == 2'd3) ? FRAME : DRIVE;
      end
      FRAME: begin
        row_d   = '0;
        state_d = DRIVE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign row_n = (state_q == DRIVE) ? ~(4'b0001 << row_q) : 4'hF;

  // Capture the settled column levels at the end of each row dwell
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q <= '1;
    end else if (latch) begin
      scan_q[row_q] <= col_s_q;
    end
  end

  function automatic logic [3:0] key_lut(input int idx);
    case (idx)
      0:       key_lut = 4'hD;
      1:       key_lut = 4'h7;
      2:       key_lut = 4'hC;
      3:       key_lut = 4'h2;
      4:       key_lut = 4'h3;
      5:       key_lut = 4'hE;
      6:       key_lut = 4'h5;
      7:       key_lut = 4'h1;
      8:       key_lut = 4'hB;
      9:       key_lut = 4'h9;
      10:      key_lut = 4'hA;
      11:      key_lut = 4'h6;
      default: key_lut = 4'hF;
    endcase
  endfunction

  // Frame encode: lowest row-major pressed key wins
  always_comb begin
    pr     = '0;
    code_c = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        pr[r*3+c] = ~scan_q[r][c];
      end
    end
    for (int i = 11; i >= 0; i--) begin
      if (pr[i]) code_c = key_lut(i);
    end
  end

  assign cand = {code_c, btn_s_q};

  // Debounce: commit once the candidate repeats enough frames
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    com_d  = com_q;
    if (state_q == FRAME) begin
      cand_d = cand;
      if (cand == cand_q) begin
        cnt_d = (cnt_q == 4'(DEBOUNCE_CNT)) ? cnt_q : cnt_q + 4'd1;
      end else begin
        cnt_d = '0;
      end
      if (cnt_d == 4'(DEBOUNCE_CNT)) com_d = cand;
    end
  end

  // Debounce state and committed-state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q <= {4'hF, 6'h3F};
      com_q  <= {4'hF, 6'h3F};
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      com_q  <= com_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef PORTA_CTRL_TURBO_EN
  localparam int FW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

  logic [FW-1:0] fcnt_q;
  logic          phase_q;

  // Autofire phase flips every TURBO_DIV frames
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else if (state_q == FRAME) begin
      if (fcnt_q == FW'(TURBO_DIV - 1)) begin
        fcnt_q  <= '0;
        phase_q <= ~phase_q;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end
  end

  assign fire_l = ~(~com_q[4] & phase_q);
  assign fire_r = ~(~com_q[5] & phase_q);
`else
  assign fire_l = com_q[4];
  assign fire_r = com_q[5];
`endif

  // Pin mux: each asserted select contributes, wired-AND when both low
  always_comb begin
    kp     = {fire_r, com_q[9:6]};
    jy     = {fire_l, com_q[3], com_q[2], com_q[1], com_q[0]};
    pins_d = (sel_key_n ? 5'h1F : kp) & (sel_joy_n ? 5'h1F : jy);
  end

  // Registered pin and key outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pins_q      <= 5'h1F;
      key_code_q  <= 4'hF;
      key_valid_q <= 1'b0;
    end else begin
      pins_q      <= pins_d;
      key_code_q  <= com_q[9:6];
      key_valid_q <= (com_q[9:6] != 4'hF);
    end
  end

  assign p1        = pins_q[0];
  assign p2        = pins_q[1];
  assign p3        = pins_q[2];
  assign p4        = pins_q[3];
  assign p6        = pins_q[4];
  assign p7        = 1'b1;
  assign p9        = 1'b1;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;

endmodule
